// File: rtl/scroll_engine.sv
// Multi-layer parallax scroll generator: per-layer prescaled offset counters with wrap or
// saturate ends, resynchronised to zero on every scene change.
module scroll_engine #(
   parameter int unsigned N_LAYERS = 3,
   parameter int unsigned SPD_W    = 8,
   parameter int unsigned POS_W    = 5,
   parameter int unsigned SCENE_W  = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clk_en,
   input  logic                      pause,
   input  logic [SCENE_W-1:0]        scene,
   input  logic [N_LAYERS*SPD_W-1:0] speed,
   input  logic [N_LAYERS-1:0]       dir,
   input  logic [N_LAYERS-1:0]       sat,
   output logic [N_LAYERS*POS_W-1:0] pos,
   output logic [N_LAYERS-1:0]       step,
   output logic [N_LAYERS-1:0]       wrap,
   output logic [N_LAYERS-1:0]       at_limit,
   output logic                      scene_chg
);

   localparam logic [POS_W-1:0] PosMax = '1;
   localparam logic [POS_W-1:0] PosOne = {{(POS_W-1){1'b0}}, 1'b1};
   localparam logic [SPD_W-1:0] KOne   = {{(SPD_W-1){1'b0}}, 1'b1};

   logic [SCENE_W-1:0]               scene_q;
   logic [N_LAYERS-1:0][SPD_W-1:0]   speed_a;
   logic [N_LAYERS-1:0][SPD_W-1:0]   k_q, k_d;
   logic [N_LAYERS-1:0][POS_W-1:0]   pos_q, pos_d;
   logic [N_LAYERS-1:0]              step_q, step_d;
   logic [N_LAYERS-1:0]              wrap_q, wrap_d;
   logic [N_LAYERS-1:0]              at_end;
   logic                             scene_chg_q;
   logic                             resync;

   assign speed_a = speed;
   assign resync  = (scene != scene_q);

   // at_end: offset sits on the end the layer is currently moving toward.
   always_comb begin
      at_end = '0;
      for (int i = 0; i < int'(N_LAYERS); i++) begin
         at_end[i] = dir[i] ? (pos_q[i] == '0) : (pos_q[i] == PosMax);
      end
   end

   always_comb begin
      k_d    = k_q;
      pos_d  = pos_q;
      step_d = '0;
      wrap_d = '0;
      if (resync) begin
         k_d   = '0;
         pos_d = '0;
      end else if (clk_en && !pause) begin
         for (int i = 0; i < int'(N_LAYERS); i++) begin
            // >= so that lowering speed below the running count steps at once.
            if (k_q[i] >= speed_a[i]) begin
               k_d[i] = '0;
               if (!(sat[i] && at_end[i])) begin
                  pos_d[i]  = dir[i] ? (pos_q[i] - PosOne) : (pos_q[i] + PosOne);
                  step_d[i] = 1'b1;
                  wrap_d[i] = at_end[i];
               end
            end else begin
               k_d[i] = k_q[i] + KOne;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scene_q     <= '0;
         k_q         <= '0;
         pos_q       <= '0;
         step_q      <= '0;
         wrap_q      <= '0;
         scene_chg_q <= 1'b0;
      end else begin
         scene_q     <= scene;
         k_q         <= k_d;
         pos_q       <= pos_d;
         step_q      <= step_d;
         wrap_q      <= wrap_d;
         scene_chg_q <= resync;
      end
   end

   assign pos       = pos_q;
   assign step      = step_q;
   assign wrap      = wrap_q;
   assign at_limit  = sat & at_end;
   assign scene_chg = scene_chg_q;

endmodule

// File: tb/tb_scroll_engine.sv
// Self-checking bench for scroll_engine: directed scenarios plus randomized traffic, all
// compared every cycle against an integer reference model of the scroll rules.
module tb_scroll_engine;

   localparam int NL  = 3;
   localparam int SW  = 8;
   localparam int PW  = 5;
   localparam int CW  = 2;
   localparam int PMX = (1 << PW) - 1;
   localparam int VW  = NL*PW + 3*NL + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clk_en = 1'b0;
   logic             pause = 1'b0;
   logic [CW-1:0]    scene = '0;
   logic [NL*SW-1:0] speed = '0;
   logic [NL-1:0]    dir = '0;
   logic [NL-1:0]    sat = '0;
   logic [NL*PW-1:0] pos;
   logic [NL-1:0]    step, wrap, at_limit;
   logic             scene_chg;
   logic [VW-1:0]    dut_vec;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   int m_k[NL];
   int m_pos[NL];
   int m_scene;
   bit m_step[NL];
   bit m_wrap[NL];
   bit m_chg;

   scroll_engine #(
      .N_LAYERS(NL), .SPD_W(SW), .POS_W(PW), .SCENE_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .pause(pause), .scene(scene),
      .speed(speed), .dir(dir), .sat(sat), .pos(pos), .step(step), .wrap(wrap),
      .at_limit(at_limit), .scene_chg(scene_chg)
   );

   always #5 clk = ~clk;

   assign dut_vec = {pos, step, wrap, at_limit, scene_chg};

   task automatic model_step();
      int spd, np;
      if (!rst_n) begin
         for (int i = 0; i < NL; i++) begin
            m_k[i] = 0; m_pos[i] = 0; m_step[i] = 0; m_wrap[i] = 0;
         end
         m_scene = 0;
         m_chg   = 0;
      end else if (int'(scene) != m_scene) begin
         m_scene = int'(scene);
         m_chg   = 1;
         for (int i = 0; i < NL; i++) begin
            m_k[i] = 0; m_pos[i] = 0; m_step[i] = 0; m_wrap[i] = 0;
         end
      end else begin
         m_chg = 0;
         for (int i = 0; i < NL; i++) begin
            m_step[i] = 0;
            m_wrap[i] = 0;
            if (clk_en && !pause) begin
               spd = int'(speed[i*SW +: SW]);
               if (m_k[i] < spd) begin
                  m_k[i]++;
               end else begin
                  m_k[i] = 0;
                  np = m_pos[i] + (dir[i] ? -1 : 1);
                  if (np < 0 || np > PMX) begin
                     if (!sat[i]) begin
                        m_pos[i]  = (np + PMX + 1) % (PMX + 1);
                        m_step[i] = 1;
                        m_wrap[i] = 1;
                     end
                  end else begin
                     m_pos[i]  = np;
                     m_step[i] = 1;
                  end
               end
            end
         end
      end
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic [NL*PW-1:0] p;
      logic [NL-1:0]    s, w, a;
      int               mp;
      for (int i = 0; i < NL; i++) begin
         mp = m_pos[i];
         p[i*PW +: PW] = mp[PW-1:0];
         s[i] = m_step[i];
         w[i] = m_wrap[i];
         a[i] = sat[i] && (dir[i] ? (m_pos[i] == 0) : (m_pos[i] == PMX));
      end
      return {p, s, w, a, m_chg};
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      scene = '0; clk_en = 1'b1; speed = '0;
      reset_dut();
      n_vec++;
      if (pos !== '0 || step !== '0 || wrap !== '0 || scene_chg !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state got pos=%h step=%b wrap=%b chg=%b exp all zero",
                  pos, step, wrap, scene_chg);
      end
      n_vec++;
      if (dut_vec !== exp_vec()) begin
         n_err++;
         $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_wrap_stepping();
      scene = '0; clk_en = 1'b0;
      reset_dut();
      speed = {8'd255, 8'd255, 8'd2}; dir = '0; sat = '0; clk_en = 1'b1;
      for (int c = 1; c <= 99; c++) begin
         tick();
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL wrap_run c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
         if (c == 3 || c == 6) begin
            n_vec++;
            if (pos[PW-1:0] !== PW'(c / 3) || step[0] !== 1'b1) begin
               n_err++;
               $display("FAIL wrap_first_steps c=%0d got pos0=%0d step0=%b exp pos0=%0d step0=1",
                        c, pos[PW-1:0], step[0], c / 3);
            end
         end
         if (c == 96) begin
            n_vec++;
            if (pos[PW-1:0] !== '0 || wrap[0] !== 1'b1) begin
               n_err++;
               $display("FAIL wrap_31_to_0 got pos0=%0d wrap0=%b exp pos0=0 wrap0=1",
                        pos[PW-1:0], wrap[0]);
            end
         end
      end
   endtask

   task automatic test_saturate();
      clk_en = 1'b0;
      reset_dut();
      speed = {8'd255, 8'd0, 8'd255}; dir = 3'b010; sat = 3'b010;
      #1;
      n_vec++;
      if (at_limit[1] !== 1'b1) begin
         n_err++;
         $display("FAIL sat_limit_low got at_limit1=%b exp 1", at_limit[1]);
      end
      clk_en = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      n_vec++;
      if (pos[PW +: PW] !== '0 || step[1] !== 1'b0) begin
         n_err++;
         $display("FAIL sat_hold_low got pos1=%0d step1=%b exp 0 0", pos[PW +: PW], step[1]);
      end
      dir = 3'b000;
      for (int c = 1; c <= 40; c++) begin
         tick();
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL sat_climb c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
      end
      n_vec++;
      if (pos[PW +: PW] !== PW'(PMX) || at_limit[1] !== 1'b1 || step[1] !== 1'b0) begin
         n_err++;
         $display("FAIL sat_top got pos1=%0d lim1=%b step1=%b exp 31 1 0",
                  pos[PW +: PW], at_limit[1], step[1]);
      end
   endtask

   task automatic test_speed_lower();
      clk_en = 1'b0; sat = '0; dir = '0;
      reset_dut();
      speed = {8'd255, 8'd255, 8'd200}; clk_en = 1'b1;
      for (int c = 0; c < 150; c++) tick();
      speed[SW-1:0] = 8'd10;
      for (int c = 1; c <= 12; c++) begin
         tick();
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL speed_lower c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
         n_vec++;
         if (step[0] !== ((c == 1 || c == 12) ? 1'b1 : 1'b0)) begin
            n_err++;
            $display("FAIL speed_lower_step c=%0d got step0=%b exp %b", c, step[0],
                     (c == 1 || c == 12));
         end
      end
   endtask

   task automatic test_scene_resync();
      clk_en = 1'b0; sat = '0; dir = '0; scene = '0;
      reset_dut();
      speed = {8'd255, 8'd255, 8'd0}; clk_en = 1'b1;
      for (int c = 0; c < 7; c++) tick();
      clk_en = 1'b0; pause = 1'b1; scene = 2'd2;
      tick();
      n_vec++;
      if (pos !== '0 || scene_chg !== 1'b1 || step !== '0 || wrap !== '0) begin
         n_err++;
         $display("FAIL scene_resync got pos=%h chg=%b step=%b exp pos=0 chg=1 step=0",
                  pos, scene_chg, step);
      end
      for (int c = 1; c <= 3; c++) begin
         tick();
         n_vec++;
         if (scene_chg !== 1'b0 || dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL scene_hold c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
      end
      pause = 1'b0;
   endtask

   task automatic test_pause_clken();
      int steps;
      scene = '0; clk_en = 1'b0;
      reset_dut();
      speed = {8'd3, 8'd1, 8'd4}; clk_en = 1'b1;
      for (int c = 0; c < 7; c++) tick();
      for (int c = 1; c <= 60; c++) begin
         pause = (c <= 20);
         tick();
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL pause c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
      end
      pause = 1'b0;
      steps = 0;
      for (int c = 0; c < 20; c++) begin
         clk_en = c[0];
         tick();
         steps += int'(step[0]);
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL half_rate c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
      end
      n_vec++;
      if (steps != 2) begin
         n_err++;
         $display("FAIL half_rate_count got %0d steps exp 2", steps);
      end
      clk_en = 1'b1;
   endtask

   task automatic test_reset_midcount();
      scene = '0; clk_en = 1'b0;
      reset_dut();
      speed = {8'd0, 8'd5, 8'd2}; dir = '0; sat = '0; clk_en = 1'b1;
      for (int c = 0; c < 12; c++) tick();
      n_vec++;
      if (pos[2*PW +: PW] !== 5'd12) begin
         n_err++;
         $display("FAIL midcount_setup got pos2=%0d exp 12", pos[2*PW +: PW]);
      end
      scene = 2'd1;
      reset_dut();
      n_vec++;
      if (pos !== '0 || step !== '0 || wrap !== '0 || scene_chg !== 1'b0) begin
         n_err++;
         $display("FAIL midcount_reset got pos=%h step=%b wrap=%b chg=%b exp zero",
                  pos, step, wrap, scene_chg);
      end
      tick();
      n_vec++;
      if (scene_chg !== 1'b1 || pos !== '0 || step !== '0) begin
         n_err++;
         $display("FAIL post_reset_resync got chg=%b pos=%h step=%b exp chg=1 pos=0 step=0",
                  scene_chg, pos, step);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         rst_n  = ($urandom_range(0, 99) != 0);
         clk_en = ($urandom_range(0, 3) != 0);
         pause  = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 29) == 0) scene = CW'($urandom);
         if ($urandom_range(0, 7) == 0) dir = NL'($urandom);
         if ($urandom_range(0, 7) == 0) sat = NL'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            for (int i = 0; i < NL; i++) begin
               speed[i*SW +: SW] = ($urandom_range(0, 7) == 0) ? SW'($urandom) :
                                                                 SW'($urandom_range(0, 3));
            end
         end
         tick();
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_wrap_stepping();
      test_saturate();
      test_speed_lower();
      test_scene_resync();
      test_pause_clken();
      test_reset_midcount();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
